// File: rtl/kth_largest_tracker.sv
// Purpose : keeps the K largest samples seen since reset/clear in a sorted register file.
// Latency : a sample accepted at edge N is visible on all outputs from cycle N+1; reads are combinational.
// Backpressure: none; one sample per cycle is always accepted, dropped only by rank or duplicate rules.
module kth_largest_tracker #(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 4,
    parameter int SIGNED     = 0,
    parameter int DISTINCT   = 0,
    localparam int IDX_W     = $clog2(K),
    localparam int CNT_W     = $clog2(K + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic [DATA_WIDTH-1:0] max_out,
    output logic [CNT_W-1:0]      fill_count,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] entry_q   [K];
    logic [DATA_WIDTH-1:0] entry_d   [K];
    logic [DATA_WIDTH-1:0] above_ent [K];
    logic [K-1:0]          occ_q;
    logic [K-1:0]          occ_d;
    logic [K-1:0]          keep_vec;
    logic [K-1:0]          above_keep;
    logic [K-1:0]          above_occ;
    logic [K-1:0]          dup_vec;
    logic                  accept;
    logic [CNT_W-1:0]      cnt;

    // Greater-or-equal under the configured signedness.
    function automatic logic ge_f(input logic [DATA_WIDTH-1:0] a,
                                  input logic [DATA_WIDTH-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) >= $signed(b);
        end
        return a >= b;
    endfunction

    // Parallel compare of din against every slot; keep_vec is a thermometer
    // because occupied entries are sorted, so its edge is the insert position.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            keep_vec[i] = occ_q[i] && ge_f(entry_q[i], din);
            dup_vec[i]  = occ_q[i] && (entry_q[i] == din);
        end
    end

    // Neighbour-above views, with a virtual always-kept slot above rank 0.
    always_comb begin
        above_keep[0] = 1'b1;
        above_occ[0]  = 1'b0;
        above_ent[0]  = '0;
        for (int i = 1; i < K; i++) begin
            above_keep[i] = keep_vec[i-1];
            above_occ[i]  = occ_q[i-1];
            above_ent[i]  = entry_q[i-1];
        end
    end

    assign accept = din_valid && !((DISTINCT != 0) && (|dup_vec));

    // Next state: hold, flush, or shift-insert; a slot keeps its value, takes
    // din at the insert point, or takes its upper neighbour below it.
    always_comb begin
        occ_d = occ_q;
        for (int i = 0; i < K; i++) begin
            entry_d[i] = entry_q[i];
        end
        if (clear) begin
            occ_d = '0;
            for (int i = 0; i < K; i++) begin
                entry_d[i] = '0;
            end
        end else if (accept) begin
            for (int i = 0; i < K; i++) begin
                if (keep_vec[i]) begin
                    entry_d[i] = entry_q[i];
                    occ_d[i]   = occ_q[i];
                end else if (above_keep[i]) begin
                    entry_d[i] = din;
                    occ_d[i]   = 1'b1;
                end else begin
                    entry_d[i] = above_ent[i];
                    occ_d[i]   = above_occ[i];
                end
            end
        end
    end

    // State registers with asynchronous flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
            for (int i = 0; i < K; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            occ_q <= occ_d;
            for (int i = 0; i < K; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    // Rank read mux; indices beyond K-1 match nothing and read as empty.
    always_comb begin
        dout       = '0;
        dout_valid = 1'b0;
        for (int i = 0; i < K; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                dout       = entry_q[i];
                dout_valid = occ_q[i];
            end
        end
    end

    // Occupancy count.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < K; i++) begin
            cnt = cnt + CNT_W'(occ_q[i]);
        end
    end

    assign fill_count = cnt;
    assign max_out    = entry_q[0];
    assign full       = occ_q[K-1];

endmodule
